// File: rtl/note_pkg.sv
// Shared types and constants for the note vote recorder and its vote bank.
package note_pkg;
    localparam int NOTE_W    = 6;
    localparam int NUM_NOTES = 64;

    typedef logic [NOTE_W-1:0] note_t;

    localparam note_t REST_NOTE = 6'd0;

    typedef enum logic [2:0] {
        IDLE,
        ACCUM,
        SCAN,
        EMIT,
        DONE
    } state_e;
endpackage

// File: rtl/note_vote_bank.sv
// One saturating vote counter per note index, with a global clear and a
// single clear-on-read port used by the sequential argmax scan.
module note_vote_bank
    import note_pkg::*;
#(
    parameter int VOTE_W = 8
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              inc_in,
    input  note_t             inc_idx_in,
    input  logic              clr_all_in,
    input  logic              rd_clr_in,
    input  note_t             rd_idx_in,
    output logic [VOTE_W-1:0] rd_cnt_out
);
    localparam logic [VOTE_W-1:0] CNT_MAX = '1;

    logic [VOTE_W-1:0] cnt_q [NUM_NOTES];
    logic [VOTE_W-1:0] cnt_d [NUM_NOTES];

    always_comb begin
        for (int i = 0; i < NUM_NOTES; i++) begin
            cnt_d[i] = cnt_q[i];
            if (clr_all_in || (rd_clr_in && rd_idx_in == note_t'(i))) begin
                cnt_d[i] = '0;
            end else if (inc_in && inc_idx_in == note_t'(i) && cnt_q[i] != CNT_MAX) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < NUM_NOTES; i++) cnt_q[i] <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign rd_cnt_out = cnt_q[rd_idx_in];
endmodule

// File: rtl/note_vote_recorder.sv
// Majority-votes note_lookup indices over fixed windows and hands one stable
// note per window, with its slot index, to the score buffer.
module note_vote_recorder
    import note_pkg::*;
#(
    parameter int TICK_CYCLES = 34816000,
    parameter int NUM_SLOTS   = 160,
    parameter int MIN_VOTES   = 2,
    parameter int VOTE_W      = 8
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              enable_in,
    input  logic [NOTE_W-1:0] note_in,
    input  logic              note_valid_in,
    output logic [NOTE_W-1:0] note_out,
    output logic [7:0]        slot_out,
    output logic              note_valid_out,
    input  logic              note_ready_in,
    output logic              busy_out,
    output logic              done_out,
    output logic              overrun_out
);
    localparam int TIMER_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TICK_CYCLES - 1);
    localparam logic [7:0]         SLOT_LAST  = 8'(NUM_SLOTS - 1);
    localparam logic [VOTE_W-1:0]  VOTES_MIN  = VOTE_W'(MIN_VOTES);
    localparam note_t              IDX_LAST   = note_t'(NUM_NOTES - 1);

    state_e             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d, timer_sat;
    logic [7:0]         slot_q, slot_d;
    note_t              scan_idx_q, scan_idx_d;
    logic [VOTE_W-1:0]  best_q, best_d, final_best;
    note_t              win_q, win_d, final_win;
    note_t              note_q, note_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               overrun_q, overrun_d;

    logic               bank_inc, bank_clr_all, bank_rd_clr;
    logic [VOTE_W-1:0]  rd_cnt;

    note_vote_bank #(.VOTE_W(VOTE_W)) u_bank (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .inc_in     (bank_inc),
        .inc_idx_in (note_in),
        .clr_all_in (bank_clr_all),
        .rd_clr_in  (bank_rd_clr),
        .rd_idx_in  (scan_idx_q),
        .rd_cnt_out (rd_cnt)
    );

    // Timer saturates outside ACCUM so a long EMIT stall cannot wrap it and
    // the late window closes on the first ACCUM cycle after the transfer.
    assign timer_sat  = (timer_q >= TIMER_LAST) ? TIMER_LAST : timer_q + 1'b1;
    assign final_best = (rd_cnt > best_q) ? rd_cnt : best_q;
    assign final_win  = (rd_cnt > best_q) ? scan_idx_q : win_q;

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        slot_d       = slot_q;
        scan_idx_d   = scan_idx_q;
        best_d       = best_q;
        win_d        = win_q;
        note_d       = note_q;
        valid_d      = valid_q;
        overrun_d    = overrun_q;
        bank_inc     = 1'b0;
        bank_clr_all = 1'b0;
        bank_rd_clr  = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable_in) begin
                    state_d      = ACCUM;
                    bank_clr_all = 1'b1;
                    timer_d      = '0;
                    slot_d       = '0;
                    overrun_d    = 1'b0;
                end
            end
            ACCUM: begin
                bank_inc = note_valid_in;
                if (timer_q >= TIMER_LAST) begin
                    state_d    = SCAN;
                    timer_d    = '0;
                    scan_idx_d = '0;
                    best_d     = '0;
                    win_d      = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            SCAN: begin
                bank_rd_clr = 1'b1;
                timer_d     = timer_sat;
                best_d      = final_best;
                win_d       = final_win;
                scan_idx_d  = scan_idx_q + 1'b1;
                if (scan_idx_q == IDX_LAST) begin
                    state_d = EMIT;
                    note_d  = (final_best >= VOTES_MIN) ? final_win : REST_NOTE;
                    valid_d = 1'b1;
                end
            end
            EMIT: begin
                timer_d = timer_sat;
                if (valid_q && note_ready_in) begin
                    valid_d = 1'b0;
                    slot_d  = slot_q + 8'd1;
                    if (timer_q >= TIMER_LAST) overrun_d = 1'b1;
                    state_d = (slot_q == SLOT_LAST) ? DONE : ACCUM;
                end
            end
            DONE: ;
            default: state_d = IDLE;
        endcase

        if (!enable_in) begin
            state_d = IDLE;
            valid_d = 1'b0;
        end

        busy_d = (state_d == ACCUM) || (state_d == SCAN) || (state_d == EMIT);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            slot_q     <= '0;
            scan_idx_q <= '0;
            best_q     <= '0;
            win_q      <= '0;
            note_q     <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            slot_q     <= slot_d;
            scan_idx_q <= scan_idx_d;
            best_q     <= best_d;
            win_q      <= win_d;
            note_q     <= note_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            overrun_q  <= overrun_d;
        end
    end

    assign note_out       = note_q;
    assign slot_out       = slot_q;
    assign note_valid_out = valid_q;
    assign busy_out       = busy_q;
    assign done_out       = done_q;
    assign overrun_out    = overrun_q;
endmodule
